// File: rtl/eth_tx_sched_if.sv
// Signal bundle between the UDP send scheduler and its user, ARP cache and MAC.
// The scheduler takes the slave side; whoever drives requests and status takes master.
interface eth_tx_sched_if;
  logic        send_req;
  logic [15:0] send_len;
  logic [11:0] fifo_level;
  logic        arp_found;
  logic        mac_not_exist;
  logic        mac_send_end;
  logic        arp_request_req;
  logic        udp_tx_req;
  logic [15:0] udp_send_data_length;
  logic        send_busy;
  logic        send_done;
  logic        send_fail;

  modport master (
    output send_req, send_len, fifo_level, arp_found, mac_not_exist, mac_send_end,
    input  arp_request_req, udp_tx_req, udp_send_data_length, send_busy, send_done, send_fail
  );

  modport slave (
    input  send_req, send_len, fifo_level, arp_found, mac_not_exist, mac_send_end,
    output arp_request_req, udp_tx_req, udp_send_data_length, send_busy, send_done, send_fail
  );
endinterface

// File: rtl/eth_tx_sched.sv
// Schedules one UDP send at a time: resolves the peer MAC via ARP with retries,
// waits for enough payload, launches the frame and enforces the inter-frame gap.
module eth_tx_sched #(
  parameter int unsigned ARP_TIMEOUT   = 125000000,
  parameter int unsigned ARP_RETRY_MAX = 3,
  parameter int unsigned IFG_CYCLES    = 12,
  parameter int unsigned TX_TIMEOUT    = 65535,
  parameter int unsigned MAX_LEN       = 1472
) (
  input  logic          gmii_tx_clk,
  input  logic          rst,
  eth_tx_sched_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, CHECK, ARP_REQ, ARP_WAIT, WAIT_DATA, TX_REQ, TX_WAIT, GAP
  } state_t;

  localparam logic [26:0] ARP_LAST  = 27'(ARP_TIMEOUT - 1);
  localparam logic [26:0] TX_LAST   = 27'(TX_TIMEOUT - 1);
  localparam logic [26:0] IFG_LAST  = 27'(IFG_CYCLES - 1);
  localparam logic [2:0]  RETRY_MAX = 3'(ARP_RETRY_MAX);
  localparam logic [15:0] LEN_MAX   = 16'(MAX_LEN);

  state_t      state, state_next;
  logic [26:0] timer;
  logic [2:0]  retry;
  logic [15:0] len_q;
  logic [1:0]  rst_sync;
  logic        rst_hold;
  logic        accept, done_next, fail_next;
  logic        arp_req_q, udp_req_q, busy_q, done_q, fail_q;

  // Reset asserts at once but releases two clock edges later, so the FSM never
  // leaves reset on an edge that races the deassertion.
  always_ff @(posedge gmii_tx_clk or posedge rst) begin
    if (rst) rst_sync <= 2'b11;
    else     rst_sync <= {rst_sync[0], 1'b0};
  end

  assign rst_hold = rst_sync[1];

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    done_next  = 1'b0;
    fail_next  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.send_req) begin
          if (bus.send_len != 16'd0 && bus.send_len <= LEN_MAX) begin
            accept     = 1'b1;
            state_next = CHECK;
          end else begin
            fail_next = 1'b1;
          end
        end
      end
      CHECK:    state_next = bus.mac_not_exist ? ARP_REQ : WAIT_DATA;
      ARP_REQ:  state_next = ARP_WAIT;
      ARP_WAIT: begin
        // mac_send_end here belongs to our own ARP frame and is deliberately ignored
        if (bus.arp_found && !bus.mac_not_exist) begin
          state_next = WAIT_DATA;
        end else if (timer == ARP_LAST) begin
          if (retry < RETRY_MAX) begin
            state_next = ARP_REQ;
          end else begin
            fail_next  = 1'b1;
            state_next = GAP;
          end
        end
      end
      WAIT_DATA: if ({4'd0, bus.fifo_level} >= len_q) state_next = TX_REQ;
      TX_REQ:    state_next = TX_WAIT;
      TX_WAIT: begin
        if (bus.mac_send_end) begin
          done_next  = 1'b1;
          state_next = GAP;
        end else if (timer == TX_LAST) begin
          fail_next  = 1'b1;
          state_next = GAP;
        end
      end
      GAP:     if (timer == IFG_LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // While the release is held off every register simply keeps its reset value.
  always_ff @(posedge gmii_tx_clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      retry     <= '0;
      len_q     <= '0;
      arp_req_q <= 1'b0;
      udp_req_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
    end else if (!rst_hold) begin
      state <= state_next;
      if (state_next != state) timer <= '0;
      else if (timer != '1)    timer <= timer + 27'd1;
      if (accept) begin
        retry <= '0;
        len_q <= bus.send_len;
      end else if (state == ARP_REQ) begin
        retry <= retry + 3'd1;
      end
      arp_req_q <= (state_next == ARP_REQ);
      udp_req_q <= (state_next == TX_REQ);
      busy_q    <= (state_next != IDLE);
      done_q    <= done_next;
      fail_q    <= fail_next;
    end
  end

  assign bus.arp_request_req      = arp_req_q;
  assign bus.udp_tx_req           = udp_req_q;
  assign bus.udp_send_data_length = len_q;
  assign bus.send_busy            = busy_q;
  assign bus.send_done            = done_q;
  assign bus.send_fail            = fail_q;

endmodule

// File: tb/tb_eth_tx_sched.sv
// Bench for eth_tx_sched: directed scenario table plus random scenarios checked
// cycle by cycle against a timeline model, and a reset-during-transmit sequence.
module tb_eth_tx_sched;

  localparam int ARP_T = 100;
  localparam int RETRY = 3;
  localparam int IFG   = 12;
  localparam int TX_T  = 200;
  localparam int MAXL  = 1472;

  // One send scenario: how the environment behaves around a single send_req.
  typedef struct {
    int len;
    int mac_ne;
    int arp_on;
    int arp_delay;
    int fifo_lo;
    int fifo_hi;
    int fifo_good;
    int send_end;
    int gap_req;
  } scen_t;

  // Cycle of each observable event, counted from the cycle send_req is presented.
  typedef struct {
    int arp_cnt;
    int udp_at;
    int done_at;
    int fail_at;
    int idle_at;
  } res_t;

  typedef struct {
    scen_t s;
    res_t  e;
  } vec_t;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_miss;
  vec_t vec[11];

  eth_tx_sched_if bus ();

  eth_tx_sched #(
    .ARP_TIMEOUT  (ARP_T),
    .ARP_RETRY_MAX(RETRY),
    .IFG_CYCLES   (IFG),
    .TX_TIMEOUT   (TX_T),
    .MAX_LEN      (MAXL)
  ) dut (
    .gmii_tx_clk(clk),
    .rst        (rst),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit len_ok(input int len);
    return len >= 1 && len <= MAXL;
  endfunction

  // Timeline model: each phase lasts a known number of cycles, so every event
  // cycle follows from simple sums over the scenario parameters.
  function automatic res_t model(input scen_t s);
    res_t r;
    int   w;
    int   g;
    r = '{0, -1, -1, -1, -1};
    if (!len_ok(s.len)) begin
      r.fail_at = 1;
      r.idle_at = 1;
      return r;
    end
    if (s.mac_ne != 0) begin
      if (s.arp_on < 1 || s.arp_on > RETRY) begin
        r.arp_cnt = RETRY;
        r.fail_at = 2 + RETRY * (ARP_T + 1);
        r.idle_at = r.fail_at + IFG;
        return r;
      end
      r.arp_cnt = s.arp_on;
      w = 2 + (s.arp_on - 1) * (ARP_T + 1) + s.arp_delay + 1;
    end else begin
      w = 2;
    end
    g = (s.fifo_lo >= s.len) ? 0 : s.fifo_good;
    r.udp_at = ((w > g) ? w : g) + 1;
    if (s.send_end > 0 && s.send_end <= TX_T) r.done_at = r.udp_at + s.send_end + 1;
    else                                      r.fail_at = r.udp_at + TX_T + 1;
    r.idle_at = ((r.done_at >= 0) ? r.done_at : r.fail_at) + IFG;
    return r;
  endfunction

  function automatic bit exp_arp(input res_t m, input int c);
    if (m.arp_cnt == 0 || c < 2) return 1'b0;
    return ((c - 2) % (ARP_T + 1) == 0) && ((c - 2) / (ARP_T + 1) < m.arp_cnt);
  endfunction

  function automatic logic [4:0] outs();
    return {bus.arp_request_req, bus.udp_tx_req, bus.send_busy, bus.send_done, bus.send_fail};
  endfunction

  task automatic check_output(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.send_req      = 1'b0;
    bus.arp_found     = 1'b0;
    bus.mac_not_exist = 1'b0;
    bus.mac_send_end  = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (bus.send_busy && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (bus.send_busy) begin
      check_output("idle wait", int'(bus.send_busy), 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
    end
    @(negedge clk);
  endtask

  // Plays one scenario cycle by cycle: sample outputs, compare, then drive inputs.
  task automatic apply_stimulus(input scen_t s, input res_t tbl, input bit use_tbl, input string tag);
    res_t m;
    bit   valid, found;
    int   last_c, n_arp, last_arp, o_udp, o_done, o_fail, o_idle, o_end;
    m      = model(s);
    valid  = len_ok(s.len);
    last_c = m.idle_at + 3;
    found  = 1'b0;
    n_arp  = 0;
    last_arp = -1000;
    o_udp  = -1; o_done = -1; o_fail = -1; o_idle = -1; o_end = -1;
    for (int c = 0; c <= last_c; c++) begin
      @(negedge clk);
      check_output($sformatf("%s c%0d {arp,udp,busy,done,fail}", tag, c), int'(outs()),
                   int'({exp_arp(m, c), c == m.udp_at, valid && c >= 1 && c < m.idle_at,
                         c == m.done_at, c == m.fail_at}));
      if (m.udp_at >= 0 && (c == m.udp_at || c == m.idle_at - 1))
        check_output($sformatf("%s c%0d length", tag, c), int'(bus.udp_send_data_length), s.len);
      if (bus.arp_request_req) begin n_arp++; last_arp = c; end
      if (bus.udp_tx_req && o_udp < 0) o_udp = c;
      if (bus.send_done && o_done < 0) o_done = c;
      if (bus.send_fail && o_fail < 0) o_fail = c;
      if ((bus.send_done || bus.send_fail) && o_end < 0) o_end = c;
      if (c >= 1 && !bus.send_busy && o_idle < 0) o_idle = c;
      if (s.mac_ne != 0 && s.arp_on >= 1 && n_arp == s.arp_on && c == last_arp + s.arp_delay)
        found = 1'b1;
      bus.send_req      = (c == 0) || (valid && s.gap_req != 0 && o_end >= 0 && c == o_end + 1);
      bus.send_len      = 16'((c == 0) ? s.len : 64);
      bus.arp_found     = found;
      bus.mac_not_exist = (s.mac_ne != 0) && !found;
      bus.mac_send_end  = (o_udp >= 0 && s.send_end > 0 && c == o_udp + s.send_end) ||
                          (s.mac_ne != 0 && n_arp > 0 && c == last_arp + 2);
      bus.fifo_level    = 12'((c >= s.fifo_good) ? s.fifo_hi : s.fifo_lo);
    end
    idle_inputs();
    if (use_tbl) begin
      check_output({tag, " arp count"}, n_arp,  tbl.arp_cnt);
      check_output({tag, " udp cycle"}, o_udp,  tbl.udp_at);
      check_output({tag, " done cycle"}, o_done, tbl.done_at);
      check_output({tag, " fail cycle"}, o_fail, tbl.fail_at);
      check_output({tag, " idle cycle"}, o_idle, tbl.idle_at);
    end
  endtask

  // Reset while a frame is on the wire must silently abandon it.
  task automatic reset_mid_tx();
    int k;
    wait_idle();
    bus.fifo_level    = 12'd100;
    bus.mac_not_exist = 1'b0;
    bus.send_len      = 16'd64;
    bus.send_req      = 1'b1;
    @(negedge clk);
    bus.send_req = 1'b0;
    k = 0;
    while (!bus.udp_tx_req && k < 10) begin
      @(negedge clk);
      k++;
    end
    check_output("rst seq udp_tx_req seen", int'(bus.udp_tx_req), 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check_output("rst seq outs at assert", int'(outs()), 0);
    check_output("rst seq length at assert", int'(bus.udp_send_data_length), 0);
    bus.mac_send_end = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_output("rst seq outs held", int'(outs()), 0);
    end
    rst = 1'b0;
    bus.mac_send_end = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check_output($sformatf("rst seq after release c%0d", c), int'(outs()), 0);
    end
  endtask

  initial begin
    scen_t s;
    res_t  none;
    int    pick;
    n_vec  = 0;
    n_miss = 0;
    none   = '{0, -1, -1, -1, -1};
    rst    = 1'b1;
    idle_inputs();
    bus.send_len   = 16'd0;
    bus.fifo_level = 12'd0;

    vec[0].s  = '{64,   0, 0, 0,  100,  100,  0, 5,   1}; vec[0].e  = '{0, 3,   9,   -1,  21};
    vec[1].s  = '{64,   1, 0, 0,  100,  100,  0, 5,   0}; vec[1].e  = '{3, -1,  -1,  305, 317};
    vec[2].s  = '{64,   1, 2, 10, 100,  100,  0, 4,   0}; vec[2].e  = '{2, 115, 120, -1,  132};
    vec[3].s  = '{0,    0, 0, 0,  100,  100,  0, 5,   0}; vec[3].e  = '{0, -1,  -1,  1,   1};
    vec[4].s  = '{1473, 0, 0, 0,  100,  100,  0, 5,   0}; vec[4].e  = '{0, -1,  -1,  1,   1};
    vec[5].s  = '{1472, 0, 0, 0,  1472, 1472, 0, 1,   0}; vec[5].e  = '{0, 3,   5,   -1,  17};
    vec[6].s  = '{64,   0, 0, 0,  10,   64,   50, 3,  0}; vec[6].e  = '{0, 51,  55,  -1,  67};
    vec[7].s  = '{100,  0, 0, 0,  100,  100,  0, 0,   0}; vec[7].e  = '{0, 3,   -1,  204, 216};
    vec[8].s  = '{100,  0, 0, 0,  100,  100,  0, 200, 0}; vec[8].e  = '{0, 3,   204, -1,  216};
    vec[9].s  = '{1,    0, 0, 0,  0,    5,    0, 1,   0}; vec[9].e  = '{0, 3,   5,   -1,  17};
    vec[10].s = '{300,  1, 1, 1,  400,  400,  0, 2,   0}; vec[10].e = '{1, 5,   8,   -1,  20};

    repeat (3) @(negedge clk);
    check_output("reset outs", int'(outs()), 0);
    check_output("reset length", int'(bus.udp_send_data_length), 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      wait_idle();
      apply_stimulus(vec[i].s, vec[i].e, 1'b1, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 30; i++) begin
      s.len = int'($urandom_range(1, MAXL));
      if ($urandom_range(0, 9) == 0) s.len = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(MAXL + 1, 65535));
      s.mac_ne    = ($urandom_range(0, 3) == 0) ? 1 : 0;
      s.arp_on    = int'($urandom_range(0, RETRY));
      s.arp_delay = int'($urandom_range(1, ARP_T - 1));
      s.fifo_lo   = (s.len >= 1 && s.len <= MAXL) ? int'($urandom_range(0, s.len - 1)) : 0;
      s.fifo_hi   = (s.len >= 1 && s.len <= MAXL) ? int'($urandom_range(s.len, 4095)) : 4095;
      s.fifo_good = int'($urandom_range(0, 60));
      pick        = int'($urandom_range(0, 9));
      s.send_end  = (pick == 0) ? 0 : (pick == 1) ? TX_T : int'($urandom_range(1, 40));
      s.gap_req   = int'($urandom_range(0, 1));
      wait_idle();
      apply_stimulus(s, none, 1'b0, $sformatf("rnd%0d", i));
    end

    reset_mid_tx();

    $display("[TB] == %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
